// File: rtl/adder_pkg.sv
// Shared defaults and the chunk-width helper for the pipelined adder.
package adder_pkg;

    localparam int N_DEF      = 32;
    localparam int STAGES_DEF = 4;

    function automatic int chunk_w(input int n, input int stages);
        return n / stages;
    endfunction

endpackage

// File: rtl/adder_n.sv
// Combinational W-bit adder with carry in/out; used as the per-stage chunk adder.
module adder_n #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         c_out
);

    assign {c_out, sum} = (W+1)'(a) + (W+1)'(b) + (W+1)'(c_in);

endmodule

// File: rtl/adder_pipelined.sv
// N-bit adder split into STAGES chunk stages with a valid/ready handshake.
// Optional signed overflow output: define ADDER_PIPELINED_OVERFLOW_EN.
module adder_pipelined
    import adder_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int STAGES = STAGES_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         c_out
`ifdef ADDER_PIPELINED_OVERFLOW_EN
    ,
    output logic         overflow
`endif
);

    localparam int W = chunk_w(N, STAGES);

    if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_cfg
        $error("adder_pipelined: illegal N=%0d STAGES=%0d", N, STAGES);
    end

    // Index k is the input side of stage k; index STAGES is the output rank.
    logic              adv;
    logic [STAGES:0]   vld_pipe;
    logic [STAGES:0]   cy_pipe;
    logic [N-1:0]      s_pipe [STAGES+1];
    logic [N-1:0]      a_pipe [STAGES];
    logic [N-1:0]      b_pipe [STAGES];

    // Whole pipeline moves or holds as one; bubbles simply ride along.
    assign in_ready    = !out_valid || out_ready;
    assign adv         = in_ready;

    assign vld_pipe[0] = in_valid;
    assign cy_pipe[0]  = c_in;
    assign s_pipe[0]   = '0;
    assign a_pipe[0]   = a;
    assign b_pipe[0]   = b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic [W-1:0] part_sum;
        logic         part_co;
        logic         v_r;
        logic         c_r;
        logic [N-1:0] s_r;

        // Operands are kept pre-shifted so the next chunk always sits in the low W bits.
        adder_n #(.W(W)) u_add (
            .a     (a_pipe[k][W-1:0]),
            .b     (b_pipe[k][W-1:0]),
            .c_in  (cy_pipe[k]),
            .sum   (part_sum),
            .c_out (part_co)
        );

        // Finished chunks enter at the top and walk down to their final place.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                s_r <= '0;
            end else if (adv) begin
                v_r <= vld_pipe[k];
                c_r <= part_co;
                s_r <= (s_pipe[k] >> W) | (N'(part_sum) << (N - W));
            end
        end

        assign vld_pipe[k+1] = v_r;
        assign cy_pipe[k+1]  = c_r;
        assign s_pipe[k+1]   = s_r;

        if (k < STAGES-1) begin : g_fwd
            logic [N-1:0] a_r;
            logic [N-1:0] b_r;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (adv) begin
                    a_r <= a_pipe[k] >> W;
                    b_r <= b_pipe[k] >> W;
                end
            end

            assign a_pipe[k+1] = a_r;
            assign b_pipe[k+1] = b_r;
        end

`ifdef ADDER_PIPELINED_OVERFLOW_EN
        // Carry into the MSB is recovered from the MSB sum bit and its operands.
        if (k == STAGES-1) begin : g_ovf
            logic ov_r;

            always_ff @(posedge clk) begin
                if (rst)
                    ov_r <= 1'b0;
                else if (adv)
                    ov_r <= a_pipe[k][W-1] ^ b_pipe[k][W-1] ^ part_sum[W-1] ^ part_co;
            end

            assign overflow = ov_r;
        end
`endif
    end

    assign out_valid = vld_pipe[STAGES];
    assign sum       = s_pipe[STAGES];
    assign c_out     = cy_pipe[STAGES];

endmodule

// File: tb/tb_adder_pipelined.sv
// Self-checking bench: four adder_pipelined instances (STAGES 4,1,2,8) against a queue-based reference.
module tb_adder_pipelined;

    localparam int N  = 32;
    localparam int ND = 4;

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ov;
        int          cyc;
        int          st;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        c_in;

    wire [ND-1:0]         irdy;
    wire [ND-1:0]         ovld;
    wire [ND-1:0]         cout_o;
    wire [ND-1:0][N-1:0]  sum_o;
    wire [ND-1:0]         ordy = {3'b111, out_ready};
`ifdef ADDER_PIPELINED_OVERFLOW_EN
    wire [ND-1:0]         ov_o;
`endif

    int n_chk;
    int n_fail;

    adder_pipelined #(.N(N), .STAGES(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[0]), .a(a), .b(b), .c_in(c_in),
        .out_valid(ovld[0]), .out_ready(out_ready), .sum(sum_o[0]), .c_out(cout_o[0])
`ifdef ADDER_PIPELINED_OVERFLOW_EN
        , .overflow(ov_o[0])
`endif
    );

    adder_pipelined #(.N(N), .STAGES(1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[1]), .a(a), .b(b), .c_in(c_in),
        .out_valid(ovld[1]), .out_ready(1'b1), .sum(sum_o[1]), .c_out(cout_o[1])
`ifdef ADDER_PIPELINED_OVERFLOW_EN
        , .overflow(ov_o[1])
`endif
    );

    adder_pipelined #(.N(N), .STAGES(2)) u_s2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[2]), .a(a), .b(b), .c_in(c_in),
        .out_valid(ovld[2]), .out_ready(1'b1), .sum(sum_o[2]), .c_out(cout_o[2])
`ifdef ADDER_PIPELINED_OVERFLOW_EN
        , .overflow(ov_o[2])
`endif
    );

    adder_pipelined #(.N(N), .STAGES(8)) u_s8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[3]), .a(a), .b(b), .c_in(c_in),
        .out_valid(ovld[3]), .out_ready(1'b1), .sum(sum_o[3]), .c_out(cout_o[3])
`ifdef ADDER_PIPELINED_OVERFLOW_EN
        , .overflow(ov_o[3])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic int s_of(input int d);
        case (d)
            0: return 4;
            1: return 1;
            2: return 2;
            default: return 8;
        endcase
    endfunction

    // Reference: plain 33-bit arithmetic; overflow from operand/result signs.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic ci);
        exp_t        e;
        logic [32:0] t;
        t    = {1'b0, x} + {1'b0, y} + {32'b0, ci};
        e.s  = t[31:0];
        e.co = t[32];
        e.ov = (x[31] == y[31]) && (t[31] != x[31]);
        e.cyc = 0;
        e.st  = 0;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Scoreboard: per-instance FIFO of expected results, filled on acceptance, drained on output.
    exp_t        sb [ND][64];
    exp_t        me;
    int          cyc;
    int          hd [ND];
    int          tl [ND];
    int          stalls [ND];
    int          npop [ND];
    logic        hold [ND];
    logic [31:0] psum [ND];
    logic        pco [ND];

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (rst) begin
                hd[d]   = tl[d];
                hold[d] = 1'b0;
            end else begin
                check($sformatf("in_ready_rule[S=%0d]", s_of(d)), irdy[d], !ovld[d] || ordy[d]);
                if (hold[d]) begin
                    check("hold_valid", ovld[d], 1);
                    check("hold_sum", sum_o[d], psum[d]);
                    check("hold_cout", cout_o[d], pco[d]);
                end
                if (ovld[d] && ordy[d]) begin
                    if (hd[d] == tl[d]) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_out[S=%0d]: actual sum %0h with no result pending at t=%0t",
                                 s_of(d), sum_o[d], $time);
                    end else begin
                        me = sb[d][hd[d] % 64];
                        hd[d]++;
                        npop[d]++;
                        check($sformatf("sum[S=%0d]", s_of(d)), sum_o[d], me.s);
                        check($sformatf("cout[S=%0d]", s_of(d)), cout_o[d], me.co);
`ifdef ADDER_PIPELINED_OVERFLOW_EN
                        check($sformatf("ovf[S=%0d]", s_of(d)), ov_o[d], me.ov);
`endif
                        check($sformatf("latency[S=%0d]", s_of(d)), cyc - me.cyc,
                              s_of(d) + stalls[d] - me.st);
                    end
                end
                if (in_valid && irdy[d]) begin
                    me     = model(a, b, c_in);
                    me.cyc = cyc;
                    me.st  = stalls[d];
                    sb[d][tl[d] % 64] = me;
                    tl[d]++;
                end
                if (!irdy[d]) stalls[d]++;
                hold[d] = ovld[d] && !ordy[d];
                psum[d] = sum_o[d];
                pco[d]  = cout_o[d];
            end
        end
        cyc++;
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge of instance 0.
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic ci);
        int n;
        bit acc;
        a = x; b = y; c_in = ci; in_valid = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = irdy[0];
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: actual not accepted after %0d cycles, required acceptance", n);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    vec_t vt [8];
    int   p [ND];
    int   st0;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c_in = 1'b0;
        vt[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vt[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vt[2] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vt[3] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
        vt[4] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
        vt[5] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0};
        vt[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vt[7] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset_out_valid", ovld[0], 0);
        check("reset_sum", sum_o[0], 0);
        check("reset_cout", cout_o[0], 0);
        check("reset_in_ready", irdy[0], 1);
        idle(1);

        // Directed vectors, one at a time, with exact STAGES=4 latency on instance 0.
        for (int i = 0; i < 8; i++) begin
            send(vt[i].a, vt[i].b, vt[i].ci);
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                if (k < 4) begin
                    check($sformatf("vec%0d_early_valid", i), ovld[0], 0);
                end else begin
                    check($sformatf("vec%0d_valid", i), ovld[0], 1);
                    check($sformatf("vec%0d_sum", i), sum_o[0], vt[i].s);
                    check($sformatf("vec%0d_cout", i), cout_o[0], vt[i].co);
`ifdef ADDER_PIPELINED_OVERFLOW_EN
                    check($sformatf("vec%0d_ovf", i), ov_o[0], vt[i].ov);
`endif
                end
            end
            idle(1);
        end

        // Back-to-back random stream.
        p[0] = npop[0];
        st0  = stalls[0];
        for (int i = 0; i < 128; i++)
            send(32'($urandom), 32'($urandom), 1'($urandom_range(0, 1)));
        idle(12);
        check("b2b_count", npop[0] - p[0], 128);
        check("b2b_in_ready_low_cycles", stalls[0] - st0, 0);

        // Consumer stalls for 6 cycles while 8 ops are offered.
        p[0] = npop[0];
        st0  = stalls[0];
        fork
            begin
                out_ready = 1'b0;
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 8; i++)
                    send(32'($urandom), 32'($urandom), 1'($urandom_range(0, 1)));
            end
        join
        idle(12);
        check("stall_count", npop[0] - p[0], 8);
        check("stall_in_ready_low_cycles", stalls[0] - st0, 2);

        // Reset with three ops in flight; inputs offered during reset must be dropped.
        for (int i = 0; i < 3; i++)
            send(32'($urandom), 32'($urandom), 1'b0);
        rst = 1'b1;
        in_valid = 1'b1;
        a = 32'hDEAD_BEEF;
        b = 32'h0BAD_F00D;
        idle(1);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("post_reset_valid[S=%0d]", s_of(d)), ovld[d], 0);
            check($sformatf("post_reset_in_ready[S=%0d]", s_of(d)), irdy[d], 1);
        end
        idle(10);
        for (int d = 0; d < ND; d++) p[d] = npop[d];
        send(32'h0000_00FF, 32'h0000_0001, 1'b1);
        idle(12);
        for (int d = 0; d < ND; d++)
            check($sformatf("post_reset_first[S=%0d]", s_of(d)), npop[d] - p[d], 1);

        // Two-hot sweep through all four depths.
        for (int d = 0; d < ND; d++) p[d] = npop[d];
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++)
                send(32'd1 << i, 32'd1 << j, 1'b0);
        idle(12);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("sweep_count[S=%0d]", s_of(d)), npop[d] - p[d], 1024);
            check($sformatf("drained[S=%0d]", s_of(d)), tl[d] - hd[d], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
